regfile_scoreboard: RTL

Parametrised successor to the core's integer register file. It adds four things: configurable register count and reset stack pointer, optional write-to-read bypass, and a per-register pending-write scoreboard driven by an issue handshake. It sits between decode/issue and writeback in the pipelined core. Decode reads operands and hazard status here; issue registers in-flight writes here; writeback retires them.

---
 rtl/regfile_scoreboard.sv | 121 ++++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with optional writeback-to-read bypass and a per-register
// pending-write scoreboard fed by the issue handshake and retired by writeback.
module regfile_scoreboard #(
    parameter int                 DWIDTH  = 32,
    parameter int                 NREGS   = 32,
    parameter int                 AWIDTH  = $clog2(NREGS),
    parameter logic [DWIDTH-1:0]  SP_INIT = 32'h0110_0000,
    parameter int                 BYPASS  = 1,
    parameter int                 CNTW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AWIDTH-1:0] rs1_i,
    input  logic [AWIDTH-1:0] rs2_i,
    output logic [DWIDTH-1:0] rs1data_o,
    output logic [DWIDTH-1:0] rs2data_o,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    input  logic              issue_valid_i,
    input  logic [AWIDTH-1:0] issue_rd_i,
    output logic              issue_ready_o,
    input  logic [AWIDTH-1:0] rd_i,
    input  logic [DWIDTH-1:0] datawb_i,
    input  logic              regwren_i,
    output logic              wb_err_o
);

    logic [DWIDTH-1:0] regs_q [NREGS];
    logic [DWIDTH-1:0] regs_d [NREGS];
    logic [CNTW-1:0]   cnt_q  [NREGS];
    logic [CNTW-1:0]   cnt_d  [NREGS];
    logic              wb_err_q, wb_err_d;

    logic wb_en;
    logic issue_acc;
    logic rs1_wb_hit, rs2_wb_hit;

    assign wb_en     = regwren_i && (rd_i != '0);
    assign issue_acc = issue_valid_i && issue_ready_o;

    // Bypass hits only matter for non-zero addresses; x0 is handled separately.
    assign rs1_wb_hit = (BYPASS != 0) && wb_en && (rd_i == rs1_i);
    assign rs2_wb_hit = (BYPASS != 0) && wb_en && (rd_i == rs2_i);

    always_comb begin
        rs1data_o  = '0;
        rs2data_o  = '0;
        rs1_busy_o = 1'b0;
        rs2_busy_o = 1'b0;
        if (rs1_i != '0) begin
            rs1data_o  = rs1_wb_hit ? datawb_i : regs_q[rs1_i];
            // A retiring writeback removes one pending write from the visible count.
            rs1_busy_o = rs1_wb_hit ? (cnt_q[rs1_i] > CNTW'(1)) : (cnt_q[rs1_i] != '0);
        end
        if (rs2_i != '0) begin
            rs2data_o  = rs2_wb_hit ? datawb_i : regs_q[rs2_i];
            rs2_busy_o = rs2_wb_hit ? (cnt_q[rs2_i] > CNTW'(1)) : (cnt_q[rs2_i] != '0);
        end
    end

    always_comb begin
        issue_ready_o = 1'b1;
        if ((issue_rd_i != '0) && (cnt_q[issue_rd_i] == '1) &&
            !(regwren_i && (rd_i == issue_rd_i))) begin
            issue_ready_o = 1'b0;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wb_en) begin
            regs_d[rd_i] = datawb_i;
        end
    end

    always_comb begin
        logic inc, hit, dec;
        inc      = 1'b0;
        hit      = 1'b0;
        dec      = 1'b0;
        wb_err_d = wb_err_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc = issue_acc && (issue_rd_i == AWIDTH'(r));
            hit = wb_en && (rd_i == AWIDTH'(r));
            // A same-cycle issue counts first, so it can cancel a writeback to an idle register.
            dec = hit && ((cnt_q[r] != '0) || inc);
            if (hit && (cnt_q[r] == '0) && !inc) begin
                wb_err_d = 1'b1;
            end
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNTW'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNTW'(1);
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= (r == 2) ? SP_INIT : '0;
                cnt_q[r]  <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err_o = wb_err_q;

endmodule
